// File: rtl/sigin_conditioner.sv
// sigin_conditioner: synchronise, deglitch and edge-count the raw meter input.
// Ports: sysclk/reset, sigin, modecontrol, gate_start -> cnt_pulse, highfreq, sig_lost.
module sigin_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int PRESCALE    = 10,
  parameter int TIMEOUT     = 100000000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic sigin,
  input  logic modecontrol,
  input  logic gate_start,
  output logic cnt_pulse,
  output logic highfreq,
  output logic sig_lost
);

  localparam int DW = $clog2(PRESCALE);
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;

  logic [FW-1:0] filt_cnt;
  logic          filt_level;
  logic          filt_level_d;
  logic          rise;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          hf_nxt;
  logic          pulse_nxt;

  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;
  logic          lost_nxt;

  // Synchroniser
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sigin};
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Level filter: the synchronised input must disagree with the
  // current level for FILT_LEN samples in a row before it flips.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      filt_cnt   <= '0;
      filt_level <= 1'b0;
    end else if (s_sync == filt_level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_cnt   <= '0;
      filt_level <= ~filt_level;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      filt_level_d <= 1'b0;
    end else begin
      filt_level_d <= filt_level;
    end
  end

  assign rise = filt_level & ~filt_level_d;

  // Range and prescaler. A gate boundary applies the requested range
  // and restarts the divider; a rise in that same cycle is counted
  // under the new range.
  always_comb begin
    hf_nxt    = highfreq;
    div_nxt   = div_cnt;
    pulse_nxt = 1'b0;
    if (gate_start) begin
      hf_nxt  = modecontrol;
      div_nxt = '0;
      if (rise) begin
        if (modecontrol) begin
          div_nxt = DIV_ONE;
        end else begin
          pulse_nxt = 1'b1;
        end
      end
    end else if (rise) begin
      if (!highfreq) begin
        pulse_nxt = 1'b1;
      end else if (div_cnt == DIV_LAST) begin
        div_nxt   = '0;
        pulse_nxt = 1'b1;
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      highfreq  <= 1'b0;
      div_cnt   <= '0;
      cnt_pulse <= 1'b0;
    end else begin
      highfreq  <= hf_nxt;
      div_cnt   <= div_nxt;
      cnt_pulse <= pulse_nxt;
    end
  end

  // Idle monitor, independent of range and gating. A rise clears
  // sig_lost together with the counter so the flag drops promptly.
  always_comb begin
    idle_nxt = idle_cnt;
    lost_nxt = 1'b0;
    if (rise) begin
      idle_nxt = '0;
    end else begin
      lost_nxt = (idle_cnt == IDLE_MAX);
      if (idle_cnt != IDLE_MAX) begin
        idle_nxt = idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      sig_lost <= 1'b0;
    end else begin
      idle_cnt <= idle_nxt;
      sig_lost <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_sigin_conditioner.sv
// tb_sigin_conditioner: randomized scenarios checked against a run-length
// model of the input conditioner (filter, range, prescale, idle, reset).
module tb_sigin_conditioner;

  localparam int SYNC = 2;
  localparam int FL   = 4;
  localparam int PS   = 10;
  localparam int TO   = 50;
  // edges from first high sample to the edge that sets cnt_pulse
  localparam int P    = SYNC + FL;

  logic sysclk = 1'b0;
  logic reset;
  logic sigin;
  logic modecontrol;
  logic gate_start;
  logic cnt_pulse;
  logic highfreq;
  logic sig_lost;

  sigin_conditioner #(
    .SYNC_STAGES(SYNC),
    .FILT_LEN(FL),
    .PRESCALE(PS),
    .TIMEOUT(TO)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .sigin(sigin),
    .modecontrol(modecontrol),
    .gate_start(gate_start),
    .cnt_pulse(cnt_pulse),
    .highfreq(highfreq),
    .sig_lost(sig_lost)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  int obs_q[$];
  int lost_rise = -1;
  int lost_fall = -1;
  logic lost_prev = 1'b0;

  always @(negedge sysclk) begin
    if (reset === 1'b0 && cnt_pulse === 1'b1) obs_q.push_back(cyc);
    if (sig_lost === 1'b1 && lost_prev !== 1'b1) lost_rise = cyc;
    if (sig_lost !== 1'b1 && lost_prev === 1'b1) lost_fall = cyc;
    lost_prev = sig_lost;
  end

  // Model: the filtered level flips once a run of the opposite input
  // level has lasted FL samples; a rising flip is counted P edges
  // after the run's first sample.
  bit m_level;
  bit run_lvl;
  int run_start;
  int run_len;
  int rise_q[$];
  int exp_q[$];

  task automatic model_reset();
    m_level = 1'b0;
    run_lvl = 1'b0;
    run_start = 0;
    run_len = 1000;
  endtask

  task automatic seg(bit lvl, int len);
    if (lvl != run_lvl) begin
      run_lvl = lvl;
      run_start = cyc + 1;
      run_len = 0;
    end
    run_len += len;
    if (run_lvl != m_level && run_len >= FL) begin
      m_level = run_lvl;
      if (lvl) rise_q.push_back(run_start + P);
    end
    sigin = lvl;
    repeat (len) @(negedge sysclk);
  endtask

  task automatic gate(bit mode, output int g);
    modecontrol = mode;
    gate_start = 1'b1;
    g = cyc + 1;
    @(negedge sysclk);
    gate_start = 1'b0;
  endtask

  task automatic clear_q();
    obs_q.delete();
    rise_q.delete();
    exp_q.delete();
  endtask

  task automatic model_low();
    exp_q.delete();
    foreach (rise_q[i]) exp_q.push_back(rise_q[i]);
  endtask

  // n-th rise since the gate (coincident rise included) pulses
  // exactly when n is a multiple of PS
  task automatic model_high();
    exp_q.delete();
    foreach (rise_q[i]) if ((i + 1) % PS == 0) exp_q.push_back(rise_q[i]);
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b1;
    sigin = 1'b0;
    modecontrol = 1'b0;
    gate_start = 1'b0;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (cnt_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt_pulse: got %b want 0", cnt_pulse);
    end
    n_checks++;
    if (highfreq !== 1'b0) begin
      n_fail++; $display("FAIL reset_highfreq: got %b want 0", highfreq);
    end
    n_checks++;
    if (sig_lost !== 1'b0) begin
      n_fail++; $display("FAIL reset_sig_lost: got %b want 0", sig_lost);
    end
    bad = 1'b0;
    sigin = 1'b1;
    modecontrol = 1'b1;
    gate_start = 1'b1;
    repeat (12) begin
      @(negedge sysclk);
      if (cnt_pulse !== 1'b0 || highfreq !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL reset_hold: got outputs active want 0");
    end
    sigin = 1'b0;
    modecontrol = 1'b0;
    gate_start = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
    model_reset();
    clear_q();
    repeat (15) @(negedge sysclk);
    n_checks++;
    if (obs_q.size() != 0 || highfreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %0d pulses hf=%b want 0 0", obs_q.size(), highfreq);
    end
  endtask

  task automatic test_low_range();
    int first;
    clear_q();
    first = cyc + 1;
    repeat (5) begin
      seg(1'b1, 20);
      seg(1'b0, 20);
    end
    seg(1'b0, 10);
    model_low();
    n_checks++;
    if (obs_q.size() != 5) begin
      n_fail++; $display("FAIL low_count: got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL low_time[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 2) begin
      n_checks++;
      if (obs_q[0] != first + P) begin
        n_fail++; $display("FAIL low_latency: got %0d want %0d", obs_q[0], first + P);
      end
      n_checks++;
      if (obs_q[1] - obs_q[0] != 40) begin
        n_fail++; $display("FAIL low_spacing: got %0d want 40", obs_q[1] - obs_q[0]);
      end
    end
    n_checks++;
    if (highfreq !== 1'b0) begin
      n_fail++; $display("FAIL low_highfreq: got %b want 0", highfreq);
    end
  endtask

  task automatic test_glitch();
    int s;
    clear_q();
    seg(1'b1, 3);
    seg(1'b0, 10);
    s = cyc + 1;
    seg(1'b1, 4);
    seg(1'b0, 12);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL glitch_count: got %0d want 1", obs_q.size());
    end
    if (obs_q.size() >= 1) begin
      n_checks++;
      if (obs_q[0] != s + P) begin
        n_fail++; $display("FAIL glitch_time: got %0d want %0d", obs_q[0], s + P);
      end
    end
  endtask

  task automatic test_random_low();
    clear_q();
    for (int i = 0; i < 60; i++) begin
      seg(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    seg(1'b0, 20);
    model_low();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL rand_time[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_high_range();
    int g;
    clear_q();
    gate(1'b1, g);
    n_checks++;
    if (highfreq !== 1'b1) begin
      n_fail++; $display("FAIL high_switch: got %b want 1", highfreq);
    end
    for (int i = 0; i < 25; i++) begin
      modecontrol = 1'($urandom_range(0, 1));
      seg(1'b1, $urandom_range(4, 10));
      modecontrol = 1'($urandom_range(0, 1));
      seg(1'b0, $urandom_range(4, 10));
    end
    modecontrol = 1'b0;
    seg(1'b0, 20);
    model_high();
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL high_count: got %0d want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL high_time[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (highfreq !== 1'b1) begin
      n_fail++; $display("FAIL high_hold: got %b want 1", highfreq);
    end
  endtask

  task automatic test_gate_coincident();
    int g;
    gate(1'b0, g);
    n_checks++;
    if (highfreq !== 1'b0) begin
      n_fail++; $display("FAIL coin_prep: got %b want 0", highfreq);
    end
    seg(1'b0, 10);
    clear_q();
    seg(1'b1, P);
    gate(1'b1, g);
    seg(1'b1, 10);
    seg(1'b0, 10);
    for (int i = 0; i < 20; i++) begin
      seg(1'b1, $urandom_range(4, 8));
      seg(1'b0, $urandom_range(4, 8));
    end
    seg(1'b0, 20);
    model_high();
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL coin_count: got %0d want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL coin_time[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 1) begin
      n_checks++;
      if (obs_q[0] == g) begin
        n_fail++; $display("FAIL coin_gate_cycle: got pulse at %0d want none", g);
      end
    end
    n_checks++;
    if (highfreq !== 1'b1) begin
      n_fail++; $display("FAIL coin_highfreq: got %b want 1", highfreq);
    end
  endtask

  task automatic test_sig_lost();
    int g;
    int e;
    clear_q();
    lost_rise = -1;
    seg(1'b1, 8);
    seg(1'b0, 8);
    e = rise_q[0];
    seg(1'b0, 20);
    gate(1'b1, g);
    seg(1'b0, 40);
    n_checks++;
    if (lost_rise != e + TO + 1) begin
      n_fail++; $display("FAIL lost_rise: got %0d want %0d", lost_rise, e + TO + 1);
    end
    n_checks++;
    if (sig_lost !== 1'b1) begin
      n_fail++; $display("FAIL lost_level: got %b want 1", sig_lost);
    end
    lost_fall = -1;
    seg(1'b1, 8);
    seg(1'b0, 8);
    e = rise_q[1];
    n_checks++;
    if (lost_fall != e) begin
      n_fail++; $display("FAIL lost_fall: got %0d want %0d", lost_fall, e);
    end
    n_checks++;
    if (sig_lost !== 1'b0) begin
      n_fail++; $display("FAIL lost_clear: got %b want 0", sig_lost);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    gate(1'b1, g);
    clear_q();
    repeat (7) begin
      seg(1'b1, 5);
      seg(1'b0, 5);
    end
    seg(1'b0, 5);
    n_checks++;
    if (obs_q.size() != 0 || highfreq !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_prep: got %0d pulses hf=%b want 0 1", obs_q.size(), highfreq);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cnt_pulse, highfreq, sig_lost} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_async: got %b want 000", {cnt_pulse, highfreq, sig_lost});
    end
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    model_reset();
    seg(1'b0, 5);
    n_checks++;
    if (highfreq !== 1'b0) begin
      n_fail++; $display("FAIL mid_release_hf: got %b want 0", highfreq);
    end
    gate(1'b1, g);
    clear_q();
    repeat (12) begin
      seg(1'b1, 5);
      seg(1'b0, 5);
    end
    seg(1'b0, 20);
    model_high();
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL mid_count: got %0d want 1", obs_q.size());
    end
    if (obs_q.size() >= 1 && exp_q.size() >= 1) begin
      n_checks++;
      if (obs_q[0] != exp_q[0]) begin
        n_fail++; $display("FAIL mid_time: got %0d want %0d", obs_q[0], exp_q[0]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_low_range();
    test_glitch();
    test_random_low();
    test_high_range();
    test_gate_coincident();
    test_sig_lost();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
